// File: rtl/feature_fetch_buffer_pkg.sv
// feature_fetch_buffer_pkg: shared widths, AXI burst constants and FSM encoding for the feature fetch path
`ifndef FEATURE_WIDTH
`define FEATURE_WIDTH 16
`endif
`ifndef MEM_DATA_WIDTH
`define MEM_DATA_WIDTH 512
`endif
`ifndef MEM_ADDR_WIDTH
`define MEM_ADDR_WIDTH 32
`endif

package feature_fetch_buffer_pkg;
  localparam int BURST_BEATS = 64;
  localparam int BURST_BYTES = 4096;
  localparam logic [7:0] AXI_ARLEN = 8'(BURST_BEATS - 1);
  localparam logic [2:0] AXI_ARSIZE = 3'b110;
  localparam logic [1:0] AXI_ARBURST = 2'b01;
  localparam logic [3:0] AXI_ARCACHE = 4'b0000;
  localparam logic [5:0] LAST_BEAT = 6'(BURST_BEATS - 1);
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    READ_REQ  = 2'd1,
    READ_DATA = 2'd2,
    CHECK     = 2'd3
  } state_t;
endpackage

// File: rtl/feature_fetch_fifo.sv
// feature_fetch_fifo: show-ahead beat FIFO with occupancy count and async active-low reset
module feature_fetch_fifo #(
  parameter int W     = 512,
  parameter int DEPTH = 256
) (
  input  logic                       system_clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [W-1:0]               wr_data,
  input  logic                       rd_en,
  output logic [W-1:0]               rd_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0] count_q, count_d;
  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(wr_en);
    rd_ptr_d = rd_ptr_q + AW'(rd_en);
    count_d  = count_q + (AW+1)'(wr_en) - (AW+1)'(rd_en);
  end
  always_ff @(posedge system_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
  // storage is not reset; the pointers alone define what is valid
  always_ff @(posedge system_clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= wr_data;
  end
  assign rd_data = mem_q[rd_ptr_q];
  assign count   = count_q;
  assign empty   = count_q == '0;
  a_no_overflow: assert property (@(posedge system_clk) disable iff (!rst_n)
    !(wr_en && !rd_en && count_q == (AW+1)'(DEPTH)));
  a_no_underflow: assert property (@(posedge system_clk) disable iff (!rst_n)
    !(rd_en && empty));
endmodule

// File: rtl/feature_fetch_buffer.sv
// feature_fetch_buffer: AXI4 read master fetching 4 KiB patch bursts into a beat FIFO
// and serializing each 512-bit beat into FEATURE_WIDTH*8-bit words
module feature_fetch_buffer
  import feature_fetch_buffer_pkg::*;
#(
  parameter int FEATURE_WIDTH  = `FEATURE_WIDTH,
  parameter int MEM_DATA_WIDTH = `MEM_DATA_WIDTH,
  parameter int MEM_ADDR_WIDTH = `MEM_ADDR_WIDTH,
  parameter int FIFO_DEPTH     = 256
) (
  input  logic                        system_clk,
  input  logic                        rst_n,
  input  logic                        refresh_fetch_addr,
  input  logic [MEM_ADDR_WIDTH-1:0]   fetch_addr,
  input  logic                        fetch_req,
  input  logic [15:0]                 fetch_patch_num,
  output logic                        fetch_finish,
  output logic                        fetch_error,
  output logic [FEATURE_WIDTH*8-1:0]  fetch_data,
  output logic                        fetch_data_valid,
  input  logic                        fetch_data_ready,
  output logic [MEM_ADDR_WIDTH-1:0]   m00_axi_araddr,
  output logic [7:0]                  m00_axi_arlen,
  output logic [2:0]                  m00_axi_arsize,
  output logic [1:0]                  m00_axi_arburst,
  output logic                        m00_axi_arlock,
  output logic [3:0]                  m00_axi_arcache,
  output logic [2:0]                  m00_axi_arprot,
  output logic [3:0]                  m00_axi_arqos,
  output logic                        m00_axi_arvalid,
  input  logic                        m00_axi_arready,
  input  logic [MEM_DATA_WIDTH-1:0]   m00_axi_rdata,
  input  logic [1:0]                  m00_axi_rresp,
  input  logic                        m00_axi_rlast,
  input  logic                        m00_axi_rvalid,
  output logic                        m00_axi_rready
);
  localparam int WW = FEATURE_WIDTH * 8;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  state_t state_q, state_d;
  logic [MEM_ADDR_WIDTH-1:0] araddr_q, araddr_d;
  logic [15:0] burst_cnt_q, burst_cnt_d;
  logic [5:0] beat_cnt_q, beat_cnt_d;
  logic keep_q, keep_d, error_q, error_d;
  logic [MEM_DATA_WIDTH-1:0] beat_q, beat_d;
  logic [1:0] idx_q, idx_d;
  logic valid_q, valid_d;
  logic [MEM_DATA_WIDTH-1:0] fifo_rdata;
  logic [CW-1:0] fifo_count;
  logic fifo_empty, fifo_rd;
  logic start, r_acc, last_acc, last_burst, credit_ok;

  assign start      = fetch_req & ~keep_q;
  assign r_acc      = m00_axi_rvalid & m00_axi_rready;
  assign last_acc   = r_acc & m00_axi_rlast;
  assign last_burst = burst_cnt_q == fetch_patch_num - 16'd1;
  // a burst is only requested once the FIFO can absorb all of it
  assign credit_ok  = 32'(fifo_count) + BURST_BEATS <= FIFO_DEPTH;

  always_comb begin
    araddr_d    = refresh_fetch_addr ? fetch_addr
                : last_acc ? araddr_q + MEM_ADDR_WIDTH'(BURST_BYTES) : araddr_q;
    burst_cnt_d = start ? '0 : last_acc ? burst_cnt_q + 16'd1 : burst_cnt_q;
    keep_d      = start | (keep_q & ~(fetch_patch_num == '0 | (last_acc & last_burst)));
    error_d     = ~start & (error_q | (r_acc & ((m00_axi_rresp != 2'b00)
                | (m00_axi_rlast ^ (beat_cnt_q == LAST_BEAT)))));
    beat_cnt_d  = (state_q == READ_REQ && m00_axi_arready) ? '0
                : r_acc ? beat_cnt_q + 6'd1 : beat_cnt_q;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      state_d = (keep_q && fetch_patch_num != '0 && credit_ok) ? READ_REQ : IDLE;
      READ_REQ:  state_d = m00_axi_arready ? READ_DATA : READ_REQ;
      READ_DATA: state_d = last_acc ? CHECK : READ_DATA;
      CHECK:     state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    m00_axi_arvalid = state_q == READ_REQ;
    m00_axi_rready  = state_q == READ_DATA;
  end

  // the output register reloads from the FIFO when empty or when its last word leaves
  assign fifo_rd = ~fifo_empty & (~valid_q | (fetch_data_ready & idx_q == 2'd3));
  always_comb begin
    beat_d  = fifo_rd ? fifo_rdata : beat_q;
    idx_d   = fifo_rd ? '0 : (valid_q & fetch_data_ready) ? idx_q + 2'd1 : idx_q;
    valid_d = fifo_rd | (valid_q & ~(fetch_data_ready & idx_q == 2'd3));
  end

  always_ff @(posedge system_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      araddr_q    <= '0;
      burst_cnt_q <= '0;
      beat_cnt_q  <= '0;
      keep_q      <= 1'b0;
      error_q     <= 1'b0;
      beat_q      <= '0;
      idx_q       <= '0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      araddr_q    <= araddr_d;
      burst_cnt_q <= burst_cnt_d;
      beat_cnt_q  <= beat_cnt_d;
      keep_q      <= keep_d;
      error_q     <= error_d;
      beat_q      <= beat_d;
      idx_q       <= idx_d;
      valid_q     <= valid_d;
    end
  end

  feature_fetch_fifo #(.W(MEM_DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .system_clk (system_clk),
    .rst_n      (rst_n),
    .wr_en      (r_acc),
    .wr_data    (m00_axi_rdata),
    .rd_en      (fifo_rd),
    .rd_data    (fifo_rdata),
    .count      (fifo_count),
    .empty      (fifo_empty)
  );

  assign fetch_data       = beat_q[WW*idx_q +: WW];
  assign fetch_data_valid = valid_q;
  assign fetch_error      = error_q;
  assign fetch_finish     = ~(keep_q | fetch_req) & fifo_empty & ~valid_q;
  assign m00_axi_araddr   = araddr_q;
  assign m00_axi_arlen    = AXI_ARLEN;
  assign m00_axi_arsize   = AXI_ARSIZE;
  assign m00_axi_arburst  = AXI_ARBURST;
  assign m00_axi_arlock   = 1'b0;
  assign m00_axi_arcache  = AXI_ARCACHE;
  assign m00_axi_arprot   = 3'b000;
  assign m00_axi_arqos    = 4'b0000;
endmodule

// File: tb/tb_feature_fetch_buffer.sv
// tb_feature_fetch_buffer: random-timing AXI slave model plus word scoreboard for feature_fetch_buffer
module tb_feature_fetch_buffer;
  logic system_clk = 1'b0;
  logic rst_n;
  logic refresh_m, refresh_s, refresh_fetch_addr;
  logic [31:0] addr_m, addr_s, fetch_addr;
  logic fetch_req;
  logic [15:0] fetch_patch_num;
  logic fetch_finish, fetch_error, fetch_data_valid, fetch_data_ready;
  logic [127:0] fetch_data;
  logic [31:0] m00_axi_araddr;
  logic [7:0] m00_axi_arlen;
  logic [2:0] m00_axi_arsize, m00_axi_arprot;
  logic [1:0] m00_axi_arburst, m00_axi_rresp;
  logic m00_axi_arlock, m00_axi_arvalid, m00_axi_arready;
  logic [3:0] m00_axi_arcache, m00_axi_arqos;
  logic [511:0] m00_axi_rdata;
  logic m00_axi_rlast, m00_axi_rvalid, m00_axi_rready;

  int vectors = 0, miscompares = 0;
  logic [31:0] exp_ar[$];
  logic [127:0] exp_w[$];
  logic [31:0] model_addr = 0;
  int ready_mode = 0, err_beat = -1, short_beats = 64, ar_seen = 0;
  bit gaps = 0, refresh_on_last = 0;
  logic [31:0] redir_addr = 0;

  assign refresh_fetch_addr = refresh_m | refresh_s;
  assign fetch_addr = refresh_s ? addr_s : addr_m;

  always #5 system_clk = ~system_clk;

  feature_fetch_buffer dut (
    .system_clk(system_clk), .rst_n(rst_n),
    .refresh_fetch_addr(refresh_fetch_addr), .fetch_addr(fetch_addr),
    .fetch_req(fetch_req), .fetch_patch_num(fetch_patch_num),
    .fetch_finish(fetch_finish), .fetch_error(fetch_error),
    .fetch_data(fetch_data), .fetch_data_valid(fetch_data_valid),
    .fetch_data_ready(fetch_data_ready),
    .m00_axi_araddr(m00_axi_araddr), .m00_axi_arlen(m00_axi_arlen),
    .m00_axi_arsize(m00_axi_arsize), .m00_axi_arburst(m00_axi_arburst),
    .m00_axi_arlock(m00_axi_arlock), .m00_axi_arcache(m00_axi_arcache),
    .m00_axi_arprot(m00_axi_arprot), .m00_axi_arqos(m00_axi_arqos),
    .m00_axi_arvalid(m00_axi_arvalid), .m00_axi_arready(m00_axi_arready),
    .m00_axi_rdata(m00_axi_rdata), .m00_axi_rresp(m00_axi_rresp),
    .m00_axi_rlast(m00_axi_rlast), .m00_axi_rvalid(m00_axi_rvalid),
    .m00_axi_rready(m00_axi_rready)
  );

  // memory contents: every 16-byte word is a function of its own byte address
  function automatic logic [127:0] word_at(logic [31:0] a);
    return {a, ~a, a * 32'h9E3779B1, a ^ 32'h5EED_C0DE};
  endfunction
  function automatic logic [511:0] beat_at(logic [31:0] a);
    return {word_at(a + 32'd48), word_at(a + 32'd32), word_at(a + 32'd16), word_at(a)};
  endfunction

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // AXI read slave; all driving and handshake bookkeeping happens on the falling edge
  initial begin
    logic [31:0] bq[$];
    logic [31:0] lat;
    int beat;
    bit hs_ar, hs_r;
    beat = 0; hs_ar = 0; hs_r = 0; lat = 0;
    m00_axi_arready = 0; m00_axi_rvalid = 0; m00_axi_rlast = 0;
    m00_axi_rdata = '0; m00_axi_rresp = 0; refresh_s = 0; addr_s = 0;
    forever begin
      @(negedge system_clk);
      if (!rst_n) begin
        bq.delete(); beat = 0; hs_ar = 0; hs_r = 0;
        m00_axi_arready = 0; m00_axi_rvalid = 0; m00_axi_rlast = 0; refresh_s = 0;
        continue;
      end
      refresh_s = 0;
      if (hs_ar) begin
        ar_seen++;
        chk("ar_single_outstanding", 128'(bq.size()), 0);
        chk("araddr", lat, exp_ar.size() != 0 ? exp_ar.pop_front() : ~lat);
        bq.push_back(lat);
      end
      if (hs_r) begin
        if (m00_axi_rlast) begin
          void'(bq.pop_front());
          beat = 0;
          short_beats = 64;
        end else beat++;
      end
      m00_axi_arready = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      if (bq.size() != 0 && (!gaps || $urandom_range(0, 2) != 0)) begin
        m00_axi_rvalid = 1;
        m00_axi_rlast  = beat == short_beats - 1;
        m00_axi_rdata  = beat_at(bq[0] + 32'(beat * 64));
        m00_axi_rresp  = beat == err_beat ? 2'b10 : 2'b00;
      end else begin
        m00_axi_rvalid = 0; m00_axi_rlast = 0; m00_axi_rresp = 0;
      end
      hs_ar = m00_axi_arvalid & m00_axi_arready;
      lat   = m00_axi_araddr;
      hs_r  = m00_axi_rvalid & m00_axi_rready;
      if (hs_r && m00_axi_rlast && refresh_on_last) begin
        refresh_s = 1; addr_s = redir_addr; refresh_on_last = 0;
      end
    end
  end

  // output monitor: pops the scoreboard on each accepted word, checks hold stability
  initial begin
    logic [127:0] held;
    bit hold;
    hold = 0; held = 0; fetch_data_ready = 0;
    forever begin
      @(negedge system_clk);
      if (!rst_n) begin hold = 0; continue; end
      if (hold) begin
        chk("hold_valid", 128'(fetch_data_valid), 1);
        chk("hold_data", fetch_data, held);
      end
      fetch_data_ready = ready_mode == 0 ? 1'b1 : ready_mode == 2 ? 1'b0 : 1'($urandom_range(0, 1));
      hold = fetch_data_valid & ~fetch_data_ready;
      held = fetch_data;
      if (fetch_data_valid && fetch_data_ready)
        chk("word", fetch_data, exp_w.size() != 0 ? exp_w.pop_front() : ~fetch_data);
    end
  end

  task automatic start_job(bit do_ref, logic [31:0] a, int n, int first_beats, bit redir, logic [31:0] ra);
    logic [31:0] base;
    @(negedge system_clk);
    if (do_ref) begin
      refresh_m = 1; addr_m = a;
      @(negedge system_clk);
      refresh_m = 0; model_addr = a;
    end
    for (int b = 0; b < n; b++) begin
      base = (redir && b > 0) ? ra + 32'((b - 1) * 4096) : model_addr + 32'(b * 4096);
      exp_ar.push_back(base);
      for (int i = 0; i < (b == 0 ? first_beats : 64) * 4; i++) exp_w.push_back(word_at(base + 32'(16 * i)));
    end
    if (n != 0) model_addr = redir ? ra + 32'((n - 1) * 4096) : model_addr + 32'(n * 4096);
    fetch_patch_num = 16'(n); fetch_req = 1;
    @(negedge system_clk);
    fetch_req = 0;
  endtask

  task automatic wait_done(string name);
    for (int i = 0; i < 30000; i++) begin
      @(negedge system_clk);
      if (fetch_finish && exp_w.size() == 0) break;
    end
    chk({name, "_finish"}, 128'(fetch_finish), 1);
    chk({name, "_words_left"}, 128'(exp_w.size()), 0);
    chk({name, "_ar_left"}, 128'(exp_ar.size()), 0);
  endtask

  task automatic chk_reset_outputs(string name);
    chk({name, "_araddr"}, m00_axi_araddr, 0);
    chk({name, "_arvalid"}, 128'(m00_axi_arvalid), 0);
    chk({name, "_rready"}, 128'(m00_axi_rready), 0);
    chk({name, "_valid"}, 128'(fetch_data_valid), 0);
    chk({name, "_data"}, fetch_data, 0);
    chk({name, "_error"}, 128'(fetch_error), 0);
    chk({name, "_finish"}, 128'(fetch_finish), 1);
  endtask

  initial begin
    int a0;
    rst_n = 0; refresh_m = 0; addr_m = 0; fetch_req = 0; fetch_patch_num = 0;
    repeat (3) @(negedge system_clk);
    chk_reset_outputs("reset");
    chk("arlen", 128'(m00_axi_arlen), 63);
    chk("arsize", 128'(m00_axi_arsize), 6);
    chk("arburst", 128'(m00_axi_arburst), 1);
    chk("arcache", 128'({m00_axi_arlock, m00_axi_arcache, m00_axi_arprot, m00_axi_arqos}), 0);
    @(negedge system_clk);
    rst_n = 1;

    start_job(1, 32'h1000_0000, 2, 64, 0, 0);
    wait_done("basic");
    chk("basic_araddr_end", m00_axi_araddr, 32'h1000_2000);

    ready_mode = 2;
    a0 = ar_seen;
    start_job(1, 32'h1100_0000, 5, 64, 0, 0);
    repeat (700) @(negedge system_clk);
    chk("credit_ar_count", 128'(ar_seen - a0), 4);
    chk("credit_arvalid_withheld", 128'(m00_axi_arvalid), 0);
    ready_mode = 1; gaps = 1;
    wait_done("backpressure");

    gaps = 0; ready_mode = 0; err_beat = 10;
    start_job(0, 0, 1, 64, 0, 0);
    wait_done("rresp");
    chk("rresp_error_set", 128'(fetch_error), 1);
    err_beat = -1;
    repeat (5) @(negedge system_clk);
    chk("error_sticky", 128'(fetch_error), 1);
    start_job(0, 0, 1, 64, 0, 0);
    chk("error_cleared_by_req", 128'(fetch_error), 0);
    wait_done("after_err");
    chk("clean_job_no_error", 128'(fetch_error), 0);

    short_beats = 63;
    start_job(0, 0, 2, 63, 0, 0);
    wait_done("early_rlast");
    chk("early_rlast_error", 128'(fetch_error), 1);

    short_beats = 65;
    start_job(0, 0, 1, 65, 0, 0);
    wait_done("missing_rlast");
    chk("missing_rlast_error", 128'(fetch_error), 1);

    refresh_on_last = 1; redir_addr = 32'h2000_0000; gaps = 1;
    start_job(1, 32'h1800_0000, 2, 64, 1, 32'h2000_0000);
    wait_done("redirect");
    chk("redirect_araddr", m00_axi_araddr, 32'h2000_1000);
    chk("redirect_no_error", 128'(fetch_error), 0);

    gaps = 0;
    a0 = ar_seen;
    @(negedge system_clk);
    fetch_patch_num = 0; fetch_req = 1;
    #1 chk("p0_finish_during_req", 128'(fetch_finish), 0);
    @(negedge system_clk);
    fetch_req = 0;
    #1 chk("p0_finish_cycle1", 128'(fetch_finish), 0);
    @(negedge system_clk);
    chk("p0_finish_cycle2", 128'(fetch_finish), 1);
    repeat (10) @(negedge system_clk);
    chk("p0_no_ar", 128'(ar_seen - a0), 0);

    gaps = 1; ready_mode = 1;
    start_job(1, 32'h3000_0000, 3, 64, 0, 0);
    for (int i = 0; i < 2000 && !m00_axi_rready; i++) @(negedge system_clk);
    repeat (20) @(negedge system_clk);
    chk("reset_mid_read_data", 128'(m00_axi_rready), 1);
    @(posedge system_clk);
    #2 rst_n = 0;
    #1 chk_reset_outputs("async_reset");
    exp_w.delete(); exp_ar.delete(); model_addr = 0;
    repeat (3) @(negedge system_clk);
    chk_reset_outputs("held_reset");
    @(posedge system_clk);
    #2 rst_n = 1;
    gaps = 0; ready_mode = 0;
    start_job(1, 32'h3400_0000, 1, 64, 0, 0);
    wait_done("post_reset");
    chk("post_reset_no_error", 128'(fetch_error), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
